// File: rtl/riscv_ex2_stage.sv
// EX2 execute stage: full ALU evaluation plus a 2-entry output/skid buffer toward EX3.
// Optional stall-cycle counter enabled by defining RISCV_EX2_PERF_EN.
module riscv_ex2_stage #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] ex1_operand_a,
  input  logic [XLEN-1:0] ex1_operand_b,
  input  logic [4:0]      ex1_rd_addr,
  input  logic [3:0]      ex1_alu_op,
  input  logic            ex1_valid,
  output logic            ex1_ready,
  input  logic            flush,
  input  logic            ex3_stall,
  output logic [XLEN-1:0] ex2_alu_partial,
  output logic [4:0]      ex2_rd_addr,
  output logic [3:0]      ex2_alu_op,
  output logic            ex2_valid
`ifdef RISCV_EX2_PERF_EN
  ,
  output logic [31:0]     perf_stall_cycles
`endif
);

  logic              out_valid_reg, out_valid_next;
  logic              skid_valid_reg, skid_valid_next;
  logic              ex1_ready_reg, ex1_ready_next;
  logic [XLEN-1:0]   out_res_reg, skid_res_reg;
  logic [4:0]        out_rd_reg, skid_rd_reg;
  logic [3:0]        out_op_reg, skid_op_reg;

  logic              accept;
  logic              out_load, out_from_skid, skid_load;
  logic [XLEN-1:0]   alu_res;
  logic [SHAMT_W-1:0] shamt;

  assign shamt = ex1_operand_b[SHAMT_W-1:0];

  always_comb begin
    alu_res = '0;
    case (ex1_alu_op[2:0])
      3'd0: begin
        if (ex1_alu_op[3])
          alu_res = {{(XLEN-1){1'b0}}, $signed(ex1_operand_a) < $signed(ex1_operand_b)};
        else
          alu_res = ex1_operand_a + ex1_operand_b;
      end
      3'd1: begin
        if (ex1_alu_op[3])
          alu_res = {{(XLEN-1){1'b0}}, ex1_operand_a < ex1_operand_b};
        else
          alu_res = ex1_operand_a - ex1_operand_b;
      end
      3'd2: alu_res = ex1_operand_a & ex1_operand_b;
      3'd3: alu_res = ex1_operand_a | ex1_operand_b;
      3'd4: alu_res = ex1_operand_a ^ ex1_operand_b;
      3'd5: alu_res = ex1_operand_a << shamt;
      3'd6: alu_res = ex1_operand_a >> shamt;
      default: alu_res = $unsigned($signed(ex1_operand_a) >>> shamt);
    endcase
  end

  assign accept = ex1_valid && ex1_ready_reg && !flush;

  always_comb begin
    out_valid_next  = out_valid_reg;
    skid_valid_next = skid_valid_reg;
    out_load        = 1'b0;
    out_from_skid   = 1'b0;
    skid_load       = 1'b0;
    if (flush) begin
      out_valid_next  = 1'b0;
      skid_valid_next = 1'b0;
    end else if (!ex3_stall) begin
      if (skid_valid_reg) begin
        out_load        = 1'b1;
        out_from_skid   = 1'b1;
        out_valid_next  = 1'b1;
        skid_valid_next = 1'b0;
      end else begin
        out_load       = accept;
        out_valid_next = accept;
      end
    end else if (!out_valid_reg) begin
      // EX3 stalled on a bubble: fill the empty output slot directly.
      out_load       = accept;
      out_valid_next = accept;
    end else if (accept) begin
      skid_load       = 1'b1;
      skid_valid_next = 1'b1;
    end
    ex1_ready_next = !skid_valid_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
      ex1_ready_reg  <= 1'b1;
    end else begin
      out_valid_reg  <= out_valid_next;
      skid_valid_reg <= skid_valid_next;
      ex1_ready_reg  <= ex1_ready_next;
    end
  end

  // Payload registers carry no reset; they are qualified by the valid flags.
  always_ff @(posedge clk) begin
    if (out_load) begin
      if (out_from_skid) begin
        out_res_reg <= skid_res_reg;
        out_rd_reg  <= skid_rd_reg;
        out_op_reg  <= skid_op_reg;
      end else begin
        out_res_reg <= alu_res;
        out_rd_reg  <= ex1_rd_addr;
        out_op_reg  <= ex1_alu_op;
      end
    end
    if (skid_load) begin
      skid_res_reg <= alu_res;
      skid_rd_reg  <= ex1_rd_addr;
      skid_op_reg  <= ex1_alu_op;
    end
  end

  assign ex1_ready       = ex1_ready_reg;
  assign ex2_valid       = out_valid_reg;
  assign ex2_alu_partial = out_res_reg;
  assign ex2_rd_addr     = out_rd_reg;
  assign ex2_alu_op      = out_op_reg;

`ifdef RISCV_EX2_PERF_EN
  logic [31:0] perf_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      perf_cnt_reg <= '0;
    else if (ex3_stall && out_valid_reg && (perf_cnt_reg != 32'hFFFF_FFFF))
      perf_cnt_reg <= perf_cnt_reg + 32'd1;
  end

  assign perf_stall_cycles = perf_cnt_reg;
`endif

endmodule

// File: tb/tb_riscv_ex2_stage.sv
// Scoreboard bench for riscv_ex2_stage: driver pushes expected results on accept,
// a monitor compares the output bundle, handshake flags and (optionally) the perf counter.
module tb_riscv_ex2_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] ex1_operand_a, ex1_operand_b;
  logic [4:0]  ex1_rd_addr;
  logic [3:0]  ex1_alu_op;
  logic        ex1_valid;
  logic        ex1_ready;
  logic        flush;
  logic        ex3_stall;
  logic [31:0] ex2_alu_partial;
  logic [4:0]  ex2_rd_addr;
  logic [3:0]  ex2_alu_op;
  logic        ex2_valid;
`ifdef RISCV_EX2_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_exp;
`endif

  riscv_ex2_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ex1_operand_a   (ex1_operand_a),
    .ex1_operand_b   (ex1_operand_b),
    .ex1_rd_addr     (ex1_rd_addr),
    .ex1_alu_op      (ex1_alu_op),
    .ex1_valid       (ex1_valid),
    .ex1_ready       (ex1_ready),
    .flush           (flush),
    .ex3_stall       (ex3_stall),
    .ex2_alu_partial (ex2_alu_partial),
    .ex2_rd_addr     (ex2_rd_addr),
    .ex2_alu_op      (ex2_alu_op),
    .ex2_valid       (ex2_valid)
`ifdef RISCV_EX2_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic [3:0]  op;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU from the instruction semantics, using wide integer arithmetic.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    longint      sa, sb;
    logic [31:0] r;
    sh = b % 32;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op[2:0])
      3'd0: r = op[3] ? ((sa < sb) ? 32'd1 : 32'd0) : 32'((longint'(a) + longint'(b)) % (64'd1 << 32));
      3'd1: r = op[3] ? ((a < b) ? 32'd1 : 32'd0) : 32'((longint'(a) - longint'(b) + (64'd1 << 32)) % (64'd1 << 32));
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = 32'((longint'(a) * (64'd1 << sh)) % (64'd1 << 32));
      3'd6: r = 32'(longint'(a) / (64'd1 << sh));
      default: begin
        r = 32'(longint'(a) / (64'd1 << sh));
        if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
      end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rv();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Drive one cycle of stimulus; record the expected result if EX2 takes the op.
  task automatic cyc(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic st, input logic fl);
    @(negedge clk);
    ex1_valid     = v;
    ex1_alu_op    = op;
    ex1_operand_a = a;
    ex1_operand_b = b;
    ex1_rd_addr   = rd;
    ex3_stall     = st;
    flush         = fl;
    #3;
    if (rst_n && v && ex1_ready && !fl) begin
      exp_t e;
      e.res = ref_alu(op, a, b);
      e.rd  = rd;
      e.op  = op;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input logic st);
    cyc(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, st, 1'b0);
  endtask

  // Monitor: compares current-cycle outputs against the scoreboard, then retires.
  always begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      exp_q.delete();
      chk("reset_valid", {31'd0, ex2_valid}, 32'd0);
      chk("reset_ready", {31'd0, ex1_ready}, 32'd1);
`ifdef RISCV_EX2_PERF_EN
      perf_exp = 32'd0;
      chk("perf_reset", perf_stall_cycles, perf_exp);
`endif
    end else begin
      chk("valid", {31'd0, ex2_valid}, {31'd0, exp_q.size() > 0});
      chk("ready", {31'd0, ex1_ready}, {31'd0, exp_q.size() < 2});
      if (ex2_valid && exp_q.size() > 0) begin
        chk("result", ex2_alu_partial, exp_q[0].res);
        chk("rd", {27'd0, ex2_rd_addr}, {27'd0, exp_q[0].rd});
        chk("op", {28'd0, ex2_alu_op}, {28'd0, exp_q[0].op});
      end
`ifdef RISCV_EX2_PERF_EN
      chk("perf", perf_stall_cycles, perf_exp);
      if (ex3_stall && ex2_valid && perf_exp != 32'hFFFF_FFFF) perf_exp = perf_exp + 1;
`endif
      if (flush) begin
        exp_q.delete();
      end else if (ex2_valid && !ex3_stall && exp_q.size() > 0) begin
        $display("EX2 out rd=%0d op=%0h res=0x%08h", ex2_rd_addr, ex2_alu_op, ex2_alu_partial);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    ex1_valid = 1'b0; ex1_alu_op = '0; ex1_operand_a = '0; ex1_operand_b = '0;
    ex1_rd_addr = '0; ex3_stall = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed ALU corner cases
    cyc(1, 4'd0, 32'hFFFF_FFFF, 32'd1, 5'd5, 0, 0);
    cyc(1, 4'd8, 32'h8000_0000, 32'd1, 5'd6, 0, 0);
    cyc(1, 4'd9, 32'h8000_0000, 32'd1, 5'd7, 0, 0);
    cyc(1, 4'd7, 32'h8000_0000, 32'h21, 5'd8, 0, 0);
    cyc(1, 4'd5, 32'd1, 32'd31, 5'd9, 0, 0);

    // Back-pressure: A into skid, B held off until the stall releases
    cyc(1, 4'd1, 32'd10, 32'd3, 5'd10, 1, 0);
    cyc(1, 4'd4, 32'h1234, 32'hFF, 5'd11, 1, 0);
    cyc(1, 4'd4, 32'h1234, 32'hFF, 5'd11, 1, 0);
    cyc(1, 4'd4, 32'h1234, 32'hFF, 5'd11, 0, 0);
    cyc(1, 4'd4, 32'h1234, 32'hFF, 5'd11, 0, 0);
    repeat (3) idle(0);

    // Bubble collapse
    cyc(1, 4'd3, 32'hF0, 32'h0F, 5'd12, 1, 0);
    idle(1);
    idle(0);
    idle(0);

    // Flush with both entries full and an op offered
    cyc(1, 4'd2, 32'hFF, 32'h0F, 5'd13, 0, 0);
    cyc(1, 4'd6, 32'h8000_0000, 32'd4, 5'd14, 1, 0);
    cyc(1, 4'd0, 32'd1, 32'd1, 5'd15, 1, 1);
    idle(0);
    idle(0);

`ifdef RISCV_EX2_PERF_EN
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    cyc(1, 4'd0, 32'd1, 32'd2, 5'd1, 0, 0);
    repeat (7) idle(1);
    cyc(0, 4'd0, 32'd0, 32'd0, 5'd0, 0, 1);
    chk("perf_seven", perf_stall_cycles, 32'd7);
    idle(0);
    chk("perf_after_flush", perf_stall_cycles, 32'd7);
    rst_n = 1'b0;
    #1;
    chk("perf_cleared", perf_stall_cycles, 32'd0);
    @(negedge clk); rst_n = 1'b1;
`endif

    // Randomized traffic with occasional flush and mid-run reset
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        @(negedge clk); ex1_valid = 1'b0; flush = 1'b0; rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
      end
      cyc($urandom_range(0, 99) < 70, 4'($urandom_range(0, 15)), rv(), rv(),
          5'($urandom_range(0, 31)), $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 3);
    end

    repeat (4) idle(0);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_ex2_stage.md
Name: riscv_ex2_stage

Overview:
Execute Stage 2 (EX2), stage 4 of the 10-stage pipeline. It drives the ex2_* bundle consumed by EX3 and completes every ALU operation, so EX3 only passes the result through. It accepts operands from EX1 with a valid/ready handshake and holds its output while EX3 is stalled. A 2-entry buffer (output register plus skid register) absorbs back-pressure without combinational ready paths, which keeps the stage under 500 ps.

Parameters:
XLEN, 32, datapath width. Only 32 is supported.
SHAMT_W, 5, shift-amount width, taken from operand_b[SHAMT_W-1:0].

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
ex1_operand_a  input  32  source operand A
ex1_operand_b  input  32  source operand B or immediate
ex1_rd_addr  input  5  destination register
ex1_alu_op  input  4  ALU opcode
ex1_valid  input  1  EX1 presents an op
ex1_ready  output  1  EX2 can accept; registered
flush  input  1  kill all ops held in EX2
ex3_stall  input  1  EX3 cannot take a new op this cycle
ex2_alu_partial  output  32  ALU result
ex2_rd_addr  output  5  destination register
ex2_alu_op  output  4  opcode, passed through
ex2_valid  output  1  output bundle valid

Behaviour:
- Reset (asynchronous, rst_n low):
  - ex2_valid=0, skid_valid=0, ex1_ready=1.
  - Data registers (result, rd, op in both OUT and SKID) have no reset. Their value is don't-care while the matching valid is 0.
- ALU decode, on alu_op[2:0]:
  - 0 ADD; 1 SUB; 2 AND; 3 OR; 4 XOR; 5 SLL; 6 SRL; 7 SRA.
  - If alu_op[3]=1: op 0 is SLT (signed, result 0 or 1) and op 1 is SLTU. Ops 2-7 with bit 3 set behave as bit 3 clear.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^32.
  - Shift amount is operand_b[4:0]; upper bits are ignored.
  - SRA replicates bit 31.
- The result is computed combinationally from EX1 inputs and captured at accept time. Latency is 1 cycle from accept to ex2_valid.
- Accept: ex1_valid && ex1_ready && !flush.
- Clock-edge priority, highest first:
  - flush=1: ex2_valid<=0, skid_valid<=0, ex1_ready<=1. Any op offered that cycle is discarded.
  - ex3_stall=0:
    - If skid_valid, OUT<=SKID and skid_valid<=0.
    - Otherwise OUT<=accepted op, and ex2_valid<=accept.
  - ex3_stall=1 and ex2_valid=0 (bubble collapse): OUT<=accepted op, and ex2_valid<=accept.
  - ex3_stall=1 and ex2_valid=1: OUT holds. An accepted op goes to SKID and skid_valid<=1.
- ex1_ready (next) = !skid_valid (next). Accept and a full SKID can never coincide.
- Output stability: while ex3_stall=1 and ex2_valid=1, all ex2_* outputs are stable.
- Ordering: ops leave in acceptance order; there is no drop or duplication without flush.
- Reset mid-operation discards both entries immediately.

Optional Feature:
RISCV_EX2_PERF_EN
- Defined:
  - Adds output port perf_stall_cycles [31:0]. It counts cycles with ex3_stall=1 && ex2_valid=1.
  - The counter resets to 0 asynchronously, saturates at 0xFFFFFFFF and is not cleared by flush.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, then ADD a=0xFFFFFFFF b=1 rd=5: next cycle ex2_valid=1, partial=0x00000000, rd=5. Reset alone gives valid=0, ready=1.
- SLT a=0x80000000 b=1 gives 1; SLTU same operands gives 0; SRA a=0x80000000 b=0x21 gives 0xC0000000; SLL a=1 b=31 gives 0x80000000.
- Back-pressure:
  - Hold ex3_stall=1 with OUT valid and feed ops A,B: A goes to SKID and ex1_ready=0 the following cycle; B waits.
  - Release the stall: outputs are A, then B, with no loss.
- Bubble collapse: ex2_valid=0 and ex3_stall=1, offer op C → ex2_valid=1 with C next cycle and SKID still empty.
- Flush with OUT and SKID both full while an op is offered: next cycle ex2_valid=0, ex1_ready=1, and the offered op never appears.
- With RISCV_EX2_PERF_EN defined, 7 stalled-valid cycles → perf_stall_cycles=7; a flush leaves it at 7; rst_n low clears it to 0.
